// File: rtl/cpu_status_ctrl.sv
// cpu_status_ctrl
// Run/halt controller at the tail of the sequential Y86 datapath. It turns
// the per-instruction status code from the status encoder into an
// architectural CPU state. It also latches the status and PC of the
// instruction that stopped the CPU, and keeps saturating cycle and
// retired-instruction counters.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        pulse: IDLE -> RUN
//   clear_i        pulse: HALT/FAULT -> IDLE, clears latched info and counters
//   instr_done_i   an instruction completes this cycle
//   stat_i         encoder status: 00 AOK, 10 ADR, 11 INS (01 treated as AOK)
//   halt_instr_i   completing instruction is halt
//   pc_i           PC of completing instruction
//   run_o          fetch/PC-update/writeback enable, high only in RUN
//   cpu_stat_o     architectural status: 00 AOK, 01 HLT, 10 ADR, 11 INS
//   done_o         high in HALT or FAULT
//   stop_pc_o      PC of the instruction that stopped the CPU
//   cycle_cnt_o    cycles spent in RUN (saturating)
//   retired_cnt_o  instructions retired (saturating)
module cpu_status_ctrl #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             instr_done_i,
    input  logic [1:0]       stat_i,
    input  logic             halt_instr_i,
    input  logic [PC_W-1:0]  pc_i,
    output logic             run_o,
    output logic [1:0]       cpu_stat_o,
    output logic             done_o,
    output logic [PC_W-1:0]  stop_pc_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retired_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_HALT  = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;

    state_t           state_q;
    logic [1:0]       cpu_stat_q;
    logic [PC_W-1:0]  stop_pc_q;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic in_run;
    logic stat_err;
    logic fault_evt;
    logic halt_evt;
    logic retire_evt;
    logic clear_evt;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_run     = (state_q == S_RUN);
    // Only the upper status bit marks an error; 01 is never driven and counts as AOK.
    assign stat_err   = stat_i[1];
    assign fault_evt  = in_run && instr_done_i && stat_err;
    assign halt_evt   = in_run && instr_done_i && !stat_err && halt_instr_i;
    // A halt retires; a faulting instruction does not.
    assign retire_evt = in_run && instr_done_i && !stat_err;
    assign clear_evt  = clear_i && ((state_q == S_HALT) || (state_q == S_FAULT));

    always_comb begin
        cycle_d   = cycle_q;
        retired_d = retired_q;
        if (clear_evt) begin
            cycle_d   = '0;
            retired_d = '0;
        end else begin
            // The cycle on which the stop event occurs is still a RUN cycle.
            if (in_run) begin
                cycle_d = sat_inc(cycle_q);
            end
            if (retire_evt) begin
                retired_d = sat_inc(retired_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cpu_stat_q <= STAT_AOK;
            stop_pc_q  <= '0;
            cycle_q    <= '0;
            retired_q  <= '0;
        end else begin
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Fault wins over halt, so a halt fetched from a bad address reports ADR.
                    if (fault_evt) begin
                        state_q    <= S_FAULT;
                        cpu_stat_q <= stat_i;
                        stop_pc_q  <= pc_i;
                    end else if (halt_evt) begin
                        state_q    <= S_HALT;
                        cpu_stat_q <= STAT_HLT;
                        stop_pc_q  <= pc_i;
                    end
                end
                S_HALT, S_FAULT: begin
                    if (clear_i) begin
                        state_q    <= S_IDLE;
                        cpu_stat_q <= STAT_AOK;
                        stop_pc_q  <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign run_o         = in_run;
    assign done_o        = (state_q == S_HALT) || (state_q == S_FAULT);
    assign cpu_stat_o    = cpu_stat_q;
    assign stop_pc_o     = stop_pc_q;
    assign cycle_cnt_o   = cycle_q;
    assign retired_cnt_o = retired_q;

endmodule

// File: tb/tb_cpu_status_ctrl.sv
module tb_cpu_status_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        clear;
    logic        instr_done;
    logic [1:0]  stat;
    logic        halt_instr;
    logic [63:0] pc;
    logic        run;
    logic [1:0]  cpu_stat;
    logic        done;
    logic [63:0] stop_pc;
    logic [31:0] cycle_cnt;
    logic [31:0] retired_cnt;

    // Narrow-counter instance for the saturation scenario
    logic        s_start;
    logic        s_clear;
    logic        s_done_in;
    logic        s_run;
    logic [1:0]  s_cpu_stat;
    logic        s_done;
    logic [63:0] s_stop_pc;
    logic [3:0]  s_cycle_cnt;
    logic [3:0]  s_retired_cnt;

    int errors = 0;
    int checks = 0;

    cpu_status_ctrl #(.PC_W(64), .CNT_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .clear_i      (clear),
        .instr_done_i (instr_done),
        .stat_i       (stat),
        .halt_instr_i (halt_instr),
        .pc_i         (pc),
        .run_o        (run),
        .cpu_stat_o   (cpu_stat),
        .done_o       (done),
        .stop_pc_o    (stop_pc),
        .cycle_cnt_o  (cycle_cnt),
        .retired_cnt_o(retired_cnt)
    );

    cpu_status_ctrl #(.PC_W(64), .CNT_W(4)) dut_small (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (s_start),
        .clear_i      (s_clear),
        .instr_done_i (s_done_in),
        .stat_i       (2'b00),
        .halt_instr_i (1'b0),
        .pc_i         (64'h0),
        .run_o        (s_run),
        .cpu_stat_o   (s_cpu_stat),
        .done_o       (s_done),
        .stop_pc_o    (s_stop_pc),
        .cycle_cnt_o  (s_cycle_cnt),
        .retired_cnt_o(s_retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; clear = 0; instr_done = 0; stat = 2'b00; halt_instr = 0; pc = 64'h0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        s_start = 0; s_clear = 0; s_done_in = 0;
        tick(); tick();
        rst = 0;
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run: got %0b want 0", run); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (cpu_stat !== 2'b00) begin errors++; $display("FAIL reset_stat: got %0b want 00", cpu_stat); end
        checks++; if (stop_pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %0h want 0", stop_pc); end
        checks++; if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, retired_cnt); end
        // IDLE ignores instruction completions
        instr_done = 1; stat = 2'b11; pc = 64'h55; tick(); idle_inputs();
        checks++; if (run !== 1'b0 || done !== 1'b0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL idle_ignore: got run=%0b done=%0b ret=%0d want 0/0/0", run, done, retired_cnt); end
    endtask

    task automatic test_halt();
        start = 1; tick(); start = 0;
        checks++; if (run !== 1'b1 || cycle_cnt !== 32'd0) begin errors++; $display("FAIL start_run: got run=%0b cyc=%0d want 1/0", run, cycle_cnt); end
        for (int i = 0; i < 5; i++) begin
            instr_done = 1; stat = 2'b00; pc = 64'(i * 10);
            tick();
        end
        halt_instr = 1; pc = 64'h32; tick(); idle_inputs();
        checks++; if (cpu_stat !== 2'b01) begin errors++; $display("FAIL halt_stat: got %0b want 01", cpu_stat); end
        checks++; if (stop_pc !== 64'h32) begin errors++; $display("FAIL halt_pc: got %0h want 32", stop_pc); end
        checks++; if (retired_cnt !== 32'd6) begin errors++; $display("FAIL halt_retired: got %0d want 6", retired_cnt); end
        checks++; if (cycle_cnt !== 32'd6) begin errors++; $display("FAIL halt_cycles: got %0d want 6", cycle_cnt); end
        checks++; if (run !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL halt_flags: got run=%0b done=%0b want 0/1", run, done); end
        instr_done = 1; pc = 64'h99; start = 1; tick(); idle_inputs();
        checks++; if (cycle_cnt !== 32'd6 || retired_cnt !== 32'd6 || stop_pc !== 64'h32) begin errors++; $display("FAIL halt_sticky: got cyc=%0d ret=%0d pc=%0h want 6/6/32", cycle_cnt, retired_cnt, stop_pc); end
    endtask

    task automatic test_fault_ins();
        clear = 1; tick(); clear = 0;
        checks++; if (done !== 1'b0 || cpu_stat !== 2'b00 || stop_pc !== 64'h0 || cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL clear_halt: got done=%0b stat=%0b pc=%0h cyc=%0d ret=%0d want all 0", done, cpu_stat, stop_pc, cycle_cnt, retired_cnt); end
        start = 1; tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            instr_done = 1; stat = 2'b00; pc = 64'(i * 4);
            tick();
        end
        stat = 2'b11; pc = 64'h14; tick();
        checks++; if (cpu_stat !== 2'b11 || stop_pc !== 64'h14) begin errors++; $display("FAIL ins_latch: got stat=%0b pc=%0h want 11/14", cpu_stat, stop_pc); end
        checks++; if (retired_cnt !== 32'd3 || cycle_cnt !== 32'd4) begin errors++; $display("FAIL ins_counts: got ret=%0d cyc=%0d want 3/4", retired_cnt, cycle_cnt); end
        stat = 2'b10; pc = 64'h99; tick(); tick(); idle_inputs();
        checks++; if (cpu_stat !== 2'b11 || stop_pc !== 64'h14 || retired_cnt !== 32'd3 || done !== 1'b1) begin errors++; $display("FAIL ins_sticky: got stat=%0b pc=%0h ret=%0d done=%0b want 11/14/3/1", cpu_stat, stop_pc, retired_cnt, done); end
    endtask

    task automatic test_fault_priority();
        clear = 1; tick(); clear = 0;
        start = 1; tick(); start = 0;
        instr_done = 1; stat = 2'b10; halt_instr = 1; pc = 64'h40; tick(); idle_inputs();
        checks++; if (cpu_stat !== 2'b10) begin errors++; $display("FAIL prio_stat: got %0b want 10", cpu_stat); end
        checks++; if (stop_pc !== 64'h40) begin errors++; $display("FAIL prio_pc: got %0h want 40", stop_pc); end
        checks++; if (retired_cnt !== 32'd0 || cycle_cnt !== 32'd1) begin errors++; $display("FAIL prio_counts: got ret=%0d cyc=%0d want 0/1", retired_cnt, cycle_cnt); end
    endtask

    task automatic test_sticky_clear();
        start = 1; tick(); start = 0;
        checks++; if (done !== 1'b1 || run !== 1'b0 || cpu_stat !== 2'b10) begin errors++; $display("FAIL fault_start: got done=%0b run=%0b stat=%0b want 1/0/10", done, run, cpu_stat); end
        clear = 1; tick(); clear = 0;
        checks++; if (run !== 1'b0 || done !== 1'b0 || cpu_stat !== 2'b00 || stop_pc !== 64'h0 || cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL fault_clear: got run=%0b done=%0b stat=%0b pc=%0h cyc=%0d ret=%0d want all 0", run, done, cpu_stat, stop_pc, cycle_cnt, retired_cnt); end
        start = 1; tick(); start = 0;
        checks++; if (run !== 1'b1 || cycle_cnt !== 32'd0) begin errors++; $display("FAIL restart: got run=%0b cyc=%0d want 1/0", run, cycle_cnt); end
        instr_done = 1; stat = 2'b01; pc = 64'h8; tick(); idle_inputs();
        checks++; if (retired_cnt !== 32'd1 || cycle_cnt !== 32'd1 || run !== 1'b1) begin errors++; $display("FAIL stat01_aok: got ret=%0d cyc=%0d run=%0b want 1/1/1", retired_cnt, cycle_cnt, run); end
        clear = 1; start = 1; tick(); idle_inputs();
        checks++; if (run !== 1'b1 || cycle_cnt !== 32'd2 || retired_cnt !== 32'd1) begin errors++; $display("FAIL clear_in_run: got run=%0b cyc=%0d ret=%0d want 1/2/1", run, cycle_cnt, retired_cnt); end
    endtask

    task automatic test_saturate();
        s_start = 1; tick(); s_start = 0;
        s_done_in = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) begin
                checks++; if (s_cycle_cnt !== 4'd15 || s_retired_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach: got cyc=%0d ret=%0d want 15/15", s_cycle_cnt, s_retired_cnt); end
            end
        end
        s_done_in = 0;
        checks++; if (s_cycle_cnt !== 4'd15 || s_retired_cnt !== 4'd15 || s_run !== 1'b1) begin errors++; $display("FAIL sat_hold: got cyc=%0d ret=%0d run=%0b want 15/15/1", s_cycle_cnt, s_retired_cnt, s_run); end
    endtask

    task automatic test_reset_in_run();
        // Main instance is still in RUN from the clear-in-RUN step
        rst = 1; start = 1; instr_done = 1; stat = 2'b11; pc = 64'h77; tick();
        rst = 0; idle_inputs();
        checks++; if (run !== 1'b0 || done !== 1'b0 || cpu_stat !== 2'b00) begin errors++; $display("FAIL rst_run_flags: got run=%0b done=%0b stat=%0b want 0/0/00", run, done, cpu_stat); end
        checks++; if (stop_pc !== 64'h0 || cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL rst_run_data: got pc=%0h cyc=%0d ret=%0d want 0/0/0", stop_pc, cycle_cnt, retired_cnt); end
        checks++; if (s_run !== 1'b0 || s_cycle_cnt !== 4'd0) begin errors++; $display("FAIL rst_small: got run=%0b cyc=%0d want 0/0", s_run, s_cycle_cnt); end
        tick();
        checks++; if (run !== 1'b0 || cycle_cnt !== 32'd0) begin errors++; $display("FAIL rst_stay_idle: got run=%0b cyc=%0d want 0/0", run, cycle_cnt); end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_fault_ins();
        test_fault_priority();
        test_sticky_clear();
        test_saturate();
        test_reset_in_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
